// File: rtl/reward_v2.sv
// Response/packet-builder for an EER-RL clustered sensor node: assembles the
// outgoing packet fields, picks the transmit power and waits for the radio grant.
module reward_v2 #(
   parameter int WORD_WIDTH = 16,
   parameter int MEMREQ_TIMEOUT = 10,
   parameter logic [WORD_WIDTH-1:0] BROADCAST_ID = 16'hFFFF
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  en,
   input  logic [WORD_WIDTH-1:0] myEnergy,
   input  logic                  iHaveData,
   input  logic                  okToSend,
   input  logic                  iAmDestination,
   input  logic [WORD_WIDTH-1:0] myNodeID,
   input  logic [WORD_WIDTH-1:0] hopsFromSink,
   input  logic [WORD_WIDTH-1:0] myQValue,
   input  logic                  role,
   input  logic                  low_E,
   input  logic [WORD_WIDTH-1:0] timeslot,
   input  logic [2:0]            fPacketType,
   input  logic [WORD_WIDTH-1:0] fSourceID,
   input  logic [WORD_WIDTH-1:0] fSourceHops,
   input  logic [WORD_WIDTH-1:0] fQValue,
   input  logic [WORD_WIDTH-1:0] fEnergyLeft,
   input  logic [WORD_WIDTH-1:0] fHopsFromCH,
   input  logic [WORD_WIDTH-1:0] fChosenCH,
   input  logic [WORD_WIDTH-1:0] chosenCH,
   input  logic [WORD_WIDTH-1:0] hopsFromCH,
   input  logic [WORD_WIDTH-1:0] chosenHop,
   input  logic [4:0]            neighborCount,
   input  logic [WORD_WIDTH-1:0] mNodeID,
   input  logic [WORD_WIDTH-1:0] mNodeHops,
   input  logic [WORD_WIDTH-1:0] mNodeQValue,
   input  logic [WORD_WIDTH-1:0] mNodeEnergy,
   input  logic [WORD_WIDTH-1:0] mNodeCHHops,
   output logic [WORD_WIDTH-1:0] rSourceID,
   output logic [WORD_WIDTH-1:0] rEnergyLeft,
   output logic [WORD_WIDTH-1:0] rQValue,
   output logic [WORD_WIDTH-1:0] rSourceHops,
   output logic [WORD_WIDTH-1:0] rDestinationID,
   output logic [WORD_WIDTH-1:0] rChosenCH,
   output logic [WORD_WIDTH-1:0] rHopsFromCH,
   output logic [2:0]            rPacketType,
   output logic [5:0]            rTimeslot,
   output logic [5:0]            nTableIndex_reward,
   output logic                  tx_setting,
   output logic                  reward_done
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] BUILD   = 3'd1;
   localparam logic [2:0] LOOKUP  = 3'd2;
   localparam logic [2:0] WAIT_TX = 3'd3;
   localparam logic [2:0] TIMEOUT = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   localparam logic [2:0] PT_HB      = 3'b000;
   localparam logic [2:0] PT_INV     = 3'b010;
   localparam logic [2:0] PT_MREQ    = 3'b011;
   localparam logic [2:0] PT_DATA    = 3'b101;
   localparam logic [2:0] PT_INVALID = 3'b111;

   localparam logic [1:0] KIND_DATA = 2'd0;
   localparam logic [1:0] KIND_HB   = 2'd1;
   localparam logic [1:0] KIND_INV  = 2'd2;
   localparam logic [1:0] KIND_MREQ = 2'd3;

   localparam logic [15:0] TIMEOUT_LAST = 16'(MEMREQ_TIMEOUT - 1);
   localparam logic [5:0]  NO_MATCH     = 6'h3F;

   logic [2:0]            state;
   logic [1:0]            kind;
   logic [15:0]           timeout_count;
   logic [WORD_WIDTH-1:0] inv_hops;
   logic                  last_entry;

   // Forwarded packet contents and most neighbor fields are not needed to build a reply.
   logic unused_inputs;
   assign unused_inputs = ^{fSourceID, fSourceHops, fQValue, fEnergyLeft, fChosenCH,
                            mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops, timeslot[WORD_WIDTH-1:6]};

   assign inv_hops    = (fHopsFromCH == '1) ? fHopsFromCH : fHopsFromCH + WORD_WIDTH'(1);
   assign last_entry  = (nTableIndex_reward + 6'd1) >= {1'b0, neighborCount};
   assign reward_done = (state == DONE);

   always_ff @(posedge clk) begin
      if (nrst) begin
         state              <= IDLE;
         kind               <= KIND_HB;
         timeout_count      <= '0;
         rSourceID          <= '0;
         rEnergyLeft        <= '0;
         rQValue            <= '0;
         rSourceHops        <= '0;
         rDestinationID     <= '0;
         rChosenCH          <= '0;
         rHopsFromCH        <= '0;
         rPacketType        <= PT_INVALID;
         rTimeslot          <= '0;
         nTableIndex_reward <= '0;
         tx_setting         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  if (iHaveData || (iAmDestination && fPacketType == PT_DATA)) begin
                     kind  <= KIND_DATA;
                     state <= BUILD;
                  end else if (fPacketType == PT_HB) begin
                     kind  <= KIND_HB;
                     state <= BUILD;
                  end else if (fPacketType == PT_INV) begin
                     kind  <= KIND_INV;
                     state <= BUILD;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            BUILD: begin
               rSourceID   <= myNodeID;
               rSourceHops <= hopsFromSink;
               rQValue     <= myQValue;
               rEnergyLeft <= myEnergy;
               rChosenCH   <= chosenCH;
               rHopsFromCH <= hopsFromCH;
               rTimeslot   <= timeslot[5:0];
               case (kind)
                  KIND_HB: begin
                     rPacketType    <= PT_HB;
                     rDestinationID <= BROADCAST_ID;
                     tx_setting     <= 1'b1;
                     state          <= low_E ? DONE : WAIT_TX;
                  end
                  KIND_INV: begin
                     rPacketType    <= PT_INV;
                     rDestinationID <= BROADCAST_ID;
                     rHopsFromCH    <= inv_hops;
                     tx_setting     <= 1'b1;
                     state          <= WAIT_TX;
                  end
                  default: begin
                     rPacketType        <= PT_DATA;
                     rDestinationID     <= chosenHop;
                     tx_setting         <= 1'b0;
                     nTableIndex_reward <= '0;
                     state              <= LOOKUP;
                  end
               endcase
            end
            // The table answers combinationally for the index presented this cycle.
            LOOKUP: begin
               if (neighborCount == 5'd0) begin
                  nTableIndex_reward <= NO_MATCH;
                  state              <= WAIT_TX;
               end else if (mNodeID == chosenHop) begin
                  state <= WAIT_TX;
               end else if (last_entry) begin
                  nTableIndex_reward <= NO_MATCH;
                  state              <= WAIT_TX;
               end else begin
                  nTableIndex_reward <= nTableIndex_reward + 6'd1;
               end
            end
            WAIT_TX: begin
               if (okToSend) begin
                  timeout_count <= '0;
                  state         <= (kind == KIND_INV) ? TIMEOUT : DONE;
               end
            end
            // A cluster head does not join anyone, so it skips the membership request.
            TIMEOUT: begin
               if (timeout_count == TIMEOUT_LAST) begin
                  if (role) begin
                     state <= DONE;
                  end else begin
                     kind           <= KIND_MREQ;
                     rPacketType    <= PT_MREQ;
                     rDestinationID <= chosenCH;
                     rHopsFromCH    <= hopsFromCH;
                     tx_setting     <= 1'b0;
                     state          <= WAIT_TX;
                  end
               end else begin
                  timeout_count <= timeout_count + 16'd1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reward_v2.sv
// Directed table-driven bench for reward_v2 plus hand-written sequences for
// the invitation timeout, cluster-head skip and mid-transaction reset.
module tb_reward_v2;

   logic        clk = 1'b0;
   logic        nrst;
   logic        en;
   logic [15:0] myEnergy;
   logic        iHaveData;
   logic        okToSend;
   logic        iAmDestination;
   logic [15:0] myNodeID, hopsFromSink, myQValue;
   logic        role;
   logic        low_E;
   logic [15:0] timeslot;
   logic [2:0]  fPacketType;
   logic [15:0] fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH;
   logic [15:0] chosenCH, hopsFromCH, chosenHop;
   logic [4:0]  neighborCount;
   logic [15:0] mNodeID, mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops;
   logic [15:0] rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID, rChosenCH, rHopsFromCH;
   logic [2:0]  rPacketType;
   logic [5:0]  rTimeslot;
   logic [5:0]  nTableIndex_reward;
   logic        tx_setting;
   logic        reward_done;

   logic [15:0] nbr_ids [64];
   int vec_count = 0;
   int miss_count = 0;

   typedef struct {
      logic [2:0]  ftype;
      logic        have_data;
      logic        am_dest;
      logic        low_e;
      logic [4:0]  count;
      logic [15:0] hop;
      int          grant_at;
      int          exp_done;
      logic [2:0]  exp_type;
      logic [15:0] exp_dest;
      logic        exp_tx;
      logic [5:0]  exp_idx;
   } vec_t;

   vec_t vecs [8];

   reward_v2 dut (
      .clk(clk), .nrst(nrst), .en(en), .myEnergy(myEnergy), .iHaveData(iHaveData),
      .okToSend(okToSend), .iAmDestination(iAmDestination), .myNodeID(myNodeID),
      .hopsFromSink(hopsFromSink), .myQValue(myQValue), .role(role), .low_E(low_E),
      .timeslot(timeslot), .fPacketType(fPacketType), .fSourceID(fSourceID),
      .fSourceHops(fSourceHops), .fQValue(fQValue), .fEnergyLeft(fEnergyLeft),
      .fHopsFromCH(fHopsFromCH), .fChosenCH(fChosenCH), .chosenCH(chosenCH),
      .hopsFromCH(hopsFromCH), .chosenHop(chosenHop), .neighborCount(neighborCount),
      .mNodeID(mNodeID), .mNodeHops(mNodeHops), .mNodeQValue(mNodeQValue),
      .mNodeEnergy(mNodeEnergy), .mNodeCHHops(mNodeCHHops), .rSourceID(rSourceID),
      .rEnergyLeft(rEnergyLeft), .rQValue(rQValue), .rSourceHops(rSourceHops),
      .rDestinationID(rDestinationID), .rChosenCH(rChosenCH), .rHopsFromCH(rHopsFromCH),
      .rPacketType(rPacketType), .rTimeslot(rTimeslot), .nTableIndex_reward(nTableIndex_reward),
      .tx_setting(tx_setting), .reward_done(reward_done)
   );

   always #5 clk = ~clk;

   // Neighbor table model: answers the index the DUT presents in the same cycle.
   assign mNodeID     = nbr_ids[nTableIndex_reward];
   assign mNodeHops   = 16'd2;
   assign mNodeQValue = 16'h1000;
   assign mNodeEnergy = 16'h4000;
   assign mNodeCHHops = 16'd1;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      vec_count++;
      if (actual !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic stepCycle(input logic en_v, input logic ok_v);
      @(negedge clk);
      en = en_v;
      okToSend = ok_v;
      @(posedge clk);
      #1;
   endtask

   task automatic checkReset();
      checkOutput("rst rSourceID", rSourceID, 16'h0);
      checkOutput("rst rEnergyLeft", rEnergyLeft, 16'h0);
      checkOutput("rst rQValue", rQValue, 16'h0);
      checkOutput("rst rSourceHops", rSourceHops, 16'h0);
      checkOutput("rst rDestinationID", rDestinationID, 16'h0);
      checkOutput("rst rChosenCH", rChosenCH, 16'h0);
      checkOutput("rst rHopsFromCH", rHopsFromCH, 16'h0);
      checkOutput("rst rPacketType", 16'(rPacketType), 16'h7);
      checkOutput("rst rTimeslot", 16'(rTimeslot), 16'h0);
      checkOutput("rst nTableIndex", 16'(nTableIndex_reward), 16'h0);
      checkOutput("rst tx_setting", 16'(tx_setting), 16'h0);
      checkOutput("rst reward_done", 16'(reward_done), 16'h0);
   endtask

   task automatic checkCommon();
      checkOutput("rSourceID", rSourceID, 16'h000C);
      checkOutput("rSourceHops", rSourceHops, 16'h0003);
      checkOutput("rQValue", rQValue, 16'h3555);
      checkOutput("rEnergyLeft", rEnergyLeft, 16'h7FFC);
      checkOutput("rChosenCH", rChosenCH, 16'h0017);
      checkOutput("rTimeslot", 16'(rTimeslot), 16'h0001);
   endtask

   // Pulse en with one vector's inputs, grant at cycle grant_at, report the cycle reward_done rose.
   task automatic applyStimulus(input vec_t v, output int done_at);
      done_at        = -1;
      fPacketType    = v.ftype;
      iHaveData      = v.have_data;
      iAmDestination = v.am_dest;
      low_E          = v.low_e;
      neighborCount  = v.count;
      chosenHop      = v.hop;
      stepCycle(1'b1, 1'b0);
      if (reward_done) done_at = 0;
      for (int c = 1; c < 40 && done_at < 0; c++) begin
         stepCycle(1'b0, c == v.grant_at);
         if (reward_done) done_at = c;
      end
      stepCycle(1'b0, 1'b0);
      iHaveData = 1'b0;
      iAmDestination = 1'b0;
   endtask

   initial begin
      int done_at;
      int done_seen;

      for (int i = 0; i < 64; i++) nbr_ids[i] = 16'h0100 + 16'(i);
      nbr_ids[0] = 16'h0005;
      nbr_ids[1] = 16'h0009;
      nbr_ids[2] = 16'h0017;

      //          ftype   hd    ad    lowE  cnt   hop       grant done type    dest      tx    idx
      vecs[0] = '{3'b000, 1'b0, 1'b0, 1'b0, 5'd3, 16'h0017, 4,    4,   3'b000, 16'hFFFF, 1'b1, 6'd0};
      vecs[1] = '{3'b000, 1'b1, 1'b0, 1'b0, 5'd3, 16'h0017, 6,    6,   3'b101, 16'h0017, 1'b0, 6'd2};
      vecs[2] = '{3'b101, 1'b0, 1'b1, 1'b0, 5'd0, 16'h0017, 4,    4,   3'b101, 16'h0017, 1'b0, 6'h3F};
      vecs[3] = '{3'b101, 1'b0, 1'b1, 1'b0, 5'd3, 16'h0042, 6,    6,   3'b101, 16'h0042, 1'b0, 6'h3F};
      vecs[4] = '{3'b101, 1'b0, 1'b1, 1'b0, 5'd3, 16'h0005, 3,    3,   3'b101, 16'h0005, 1'b0, 6'd0};
      vecs[5] = '{3'b000, 1'b0, 1'b0, 1'b1, 5'd3, 16'h0005, 10,   1,   3'b000, 16'hFFFF, 1'b1, 6'd0};
      vecs[6] = '{3'b111, 1'b0, 1'b0, 1'b0, 5'd3, 16'h0005, 10,   0,   3'b000, 16'hFFFF, 1'b1, 6'd0};
      vecs[7] = '{3'b101, 1'b0, 1'b0, 1'b0, 5'd3, 16'h0005, 10,   0,   3'b000, 16'hFFFF, 1'b1, 6'd0};

      nrst = 1'b1; en = 1'b0; okToSend = 1'b0; iHaveData = 1'b0; iAmDestination = 1'b0;
      myNodeID = 16'h000C; hopsFromSink = 16'd3; myQValue = 16'h3555; myEnergy = 16'h7FFC;
      role = 1'b0; low_E = 1'b0; timeslot = 16'd1; fPacketType = 3'b000;
      fSourceID = 16'h0023; fSourceHops = 16'd4; fQValue = 16'h2000; fEnergyLeft = 16'h6000;
      fHopsFromCH = 16'd1; fChosenCH = 16'h0017; chosenCH = 16'h0017; hopsFromCH = 16'd1;
      chosenHop = 16'h0017; neighborCount = 5'd3;
      @(posedge clk); @(posedge clk); #1;
      checkReset();
      @(negedge clk); nrst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i], done_at);
         $display("[TB] vector %0d done at cycle %0d", i, done_at);
         checkOutput("done cycle", 16'(done_at), 16'(vecs[i].exp_done));
         checkOutput("done pulse width", 16'(reward_done), 16'h0);
         checkOutput("rPacketType", 16'(rPacketType), 16'(vecs[i].exp_type));
         checkOutput("rDestinationID", rDestinationID, vecs[i].exp_dest);
         checkOutput("tx_setting", 16'(tx_setting), 16'(vecs[i].exp_tx));
         checkOutput("nTableIndex", 16'(nTableIndex_reward), 16'(vecs[i].exp_idx));
         checkOutput("rHopsFromCH", rHopsFromCH, 16'h0001);
         checkCommon();
      end

      // Invitation ripple: broadcast, then after the timeout a membership request to the chosen CH.
      fPacketType = 3'b010; fHopsFromCH = 16'd1; role = 1'b0; low_E = 1'b0;
      done_at = -1;
      stepCycle(1'b1, 1'b0);
      stepCycle(1'b0, 1'b0);
      checkOutput("inv rPacketType", 16'(rPacketType), 16'h2);
      checkOutput("inv rHopsFromCH", rHopsFromCH, 16'h0002);
      checkOutput("inv tx_setting", 16'(tx_setting), 16'h1);
      checkOutput("inv rDestinationID", rDestinationID, 16'hFFFF);
      for (int c = 2; c < 30 && done_at < 0; c++) begin
         iHaveData = (c == 5);
         stepCycle(c == 5, (c == 2) || (c == 7) || (c == 14));
         if (reward_done) done_at = c;
         if (c == 11) checkOutput("inv type before timeout", 16'(rPacketType), 16'h2);
         if (c == 12) begin
            checkOutput("mreq rPacketType", 16'(rPacketType), 16'h3);
            checkOutput("mreq rDestinationID", rDestinationID, 16'h0017);
            checkOutput("mreq rHopsFromCH", rHopsFromCH, 16'h0001);
            checkOutput("mreq tx_setting", 16'(tx_setting), 16'h0);
         end
      end
      iHaveData = 1'b0;
      checkOutput("mreq done cycle", 16'(done_at), 16'd14);
      stepCycle(1'b0, 1'b0);

      // Cluster head with saturated hop count: no membership request after the timeout.
      fHopsFromCH = 16'hFFFF; role = 1'b1;
      done_at = -1;
      stepCycle(1'b1, 1'b0);
      stepCycle(1'b0, 1'b0);
      checkOutput("inv sat rHopsFromCH", rHopsFromCH, 16'hFFFF);
      for (int c = 2; c < 30 && done_at < 0; c++) begin
         stepCycle(1'b0, c == 2);
         if (reward_done) done_at = c;
      end
      checkOutput("ch skip done cycle", 16'(done_at), 16'd12);
      checkOutput("ch skip rPacketType", 16'(rPacketType), 16'h2);
      stepCycle(1'b0, 1'b0);
      role = 1'b0; fHopsFromCH = 16'd1;

      // Reset while waiting for the grant, then a late grant must not complete anything.
      fPacketType = 3'b000;
      stepCycle(1'b1, 1'b0);
      stepCycle(1'b0, 1'b0);
      checkOutput("pre-reset tx_setting", 16'(tx_setting), 16'h1);
      @(negedge clk); nrst = 1'b1;
      @(posedge clk); #1;
      checkReset();
      @(negedge clk); nrst = 1'b0;
      done_seen = 0;
      for (int c = 0; c < 6; c++) begin
         stepCycle(1'b0, 1'b1);
         if (reward_done) done_seen++;
      end
      checkOutput("late grant done count", 16'(done_seen), 16'd0);
      checkOutput("late grant rPacketType", 16'(rPacketType), 16'h7);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
